// File: rtl/itch_pkg.sv
// itch_pkg: shared constants and helpers for the ITCH transmit-side serializer.
//   - 4-bit message type codes and their ASCII type bytes
//   - side ASCII constants
//   - per-type byte lengths and msg_len(), including the optional timestamp bytes
//   - serializer state enum and big-endian byte-extraction helpers
// Optional feature macro: ITCH_TIMESTAMP_EN (adds a 6-byte timestamp after the type byte).
package itch_pkg;

  localparam logic [3:0] TypeAdd     = 4'd1;
  localparam logic [3:0] TypeDelete  = 4'd2;
  localparam logic [3:0] TypeCancel  = 4'd3;
  localparam logic [3:0] TypeExecute = 4'd4;
  localparam logic [3:0] TypeReplace = 4'd5;

  localparam logic [7:0] AsciiAdd     = 8'h41;  // 'A'
  localparam logic [7:0] AsciiDelete  = 8'h44;  // 'D'
  localparam logic [7:0] AsciiCancel  = 8'h58;  // 'X'
  localparam logic [7:0] AsciiExecute = 8'h45;  // 'E'
  localparam logic [7:0] AsciiReplace = 8'h55;  // 'U'
  localparam logic [7:0] AsciiBuy     = 8'h42;  // 'B'
  localparam logic [7:0] AsciiSell    = 8'h53;  // 'S'

`ifdef ITCH_TIMESTAMP_EN
  localparam int unsigned TsBytes = 6;
`else
  localparam int unsigned TsBytes = 0;
`endif

  localparam logic [4:0] LenAdd     = 5'(18 + TsBytes);
  localparam logic [4:0] LenDelete  = 5'(9 + TsBytes);
  localparam logic [4:0] LenCancel  = 5'(13 + TsBytes);
  localparam logic [4:0] LenExecute = 5'(13 + TsBytes);
  localparam logic [4:0] LenReplace = 5'(25 + TsBytes);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap
  } state_e;

  // Zero length marks an unsupported type.
  function automatic logic [4:0] msg_len(input logic [3:0] t);
    logic [4:0] len;
    case (t)
      TypeAdd:     len = LenAdd;
      TypeDelete:  len = LenDelete;
      TypeCancel:  len = LenCancel;
      TypeExecute: len = LenExecute;
      TypeReplace: len = LenReplace;
      default:     len = 5'd0;
    endcase
    return len;
  endfunction

  function automatic logic [7:0] type_ascii(input logic [3:0] t);
    logic [7:0] a;
    case (t)
      TypeAdd:     a = AsciiAdd;
      TypeDelete:  a = AsciiDelete;
      TypeCancel:  a = AsciiCancel;
      TypeExecute: a = AsciiExecute;
      TypeReplace: a = AsciiReplace;
      default:     a = 8'h00;
    endcase
    return a;
  endfunction

  // Byte k of a 64-bit value, k=0 being the most significant byte.
  function automatic logic [7:0] be_byte64(input logic [63:0] v, input logic [2:0] k);
    logic [63:0] s;
    s = v << {k, 3'b000};
    return s[63:56];
  endfunction

  // Byte k of a 32-bit value, k=0 being the most significant byte.
  function automatic logic [7:0] be_byte32(input logic [31:0] v, input logic [1:0] k);
    logic [31:0] s;
    s = v << {k, 3'b000};
    return s[31:24];
  endfunction

endpackage

// File: rtl/itch_byte_mux.sv
// itch_byte_mux: combinational layout logic. Picks byte number idx of an ITCH message
// from the field bundle, big-endian, according to the per-type layout.
// Ports:
//   type_code  in  4   message type code
//   order_ref  in  64  order reference
//   side       in  1   0=buy, 1=sell
//   shares     in  32  share count
//   price      in  32  price
//   new_ref    in  64  replacement reference (REPLACE)
//   timestamp  in  48  inserted after the type byte when ITCH_TIMESTAMP_EN is defined
//   idx        in  5   byte index within the message
//   byte_val   out 8   selected byte (0 when idx is past the end)
// Optional feature macro: ITCH_TIMESTAMP_EN.
module itch_byte_mux
  import itch_pkg::*;
(
  input  logic [3:0]  type_code,
  input  logic [63:0] order_ref,
  input  logic        side,
  input  logic [31:0] shares,
  input  logic [31:0] price,
  input  logic [63:0] new_ref,
  input  logic [47:0] timestamp,
  input  logic [4:0]  idx,
  output logic [7:0]  byte_val
);

  // Position after the type byte and optional timestamp; body starts at 1.
  logic [4:0] body;

`ifndef ITCH_TIMESTAMP_EN
  logic unused_ts;
  assign unused_ts = ^timestamp;
`endif

  always_comb begin
    byte_val = 8'h00;
    body     = idx - 5'(TsBytes);
    if (idx == 5'd0) begin
      byte_val = type_ascii(type_code);
`ifdef ITCH_TIMESTAMP_EN
    end else if (idx <= 5'd6) begin
      // 48-bit stamp sits in the low 6 bytes of a 64-bit word: bytes 2..7.
      byte_val = be_byte64({16'h0000, timestamp}, 3'(idx + 5'd1));
`endif
    end else begin
      case (type_code)
        TypeAdd: begin
          if (body <= 5'd8)       byte_val = be_byte64(order_ref, 3'(body - 5'd1));
          else if (body == 5'd9)  byte_val = side ? AsciiSell : AsciiBuy;
          else if (body <= 5'd13) byte_val = be_byte32(shares, 2'(body - 5'd10));
          else if (body <= 5'd17) byte_val = be_byte32(price, 2'(body - 5'd14));
        end
        TypeDelete: begin
          if (body <= 5'd8) byte_val = be_byte64(order_ref, 3'(body - 5'd1));
        end
        TypeCancel, TypeExecute: begin
          if (body <= 5'd8)       byte_val = be_byte64(order_ref, 3'(body - 5'd1));
          else if (body <= 5'd12) byte_val = be_byte32(shares, 2'(body - 5'd9));
        end
        TypeReplace: begin
          if (body <= 5'd8)       byte_val = be_byte64(order_ref, 3'(body - 5'd1));
          else if (body <= 5'd16) byte_val = be_byte64(new_ref, 3'(body - 5'd9));
          else if (body <= 5'd20) byte_val = be_byte32(shares, 2'(body - 5'd17));
          else if (body <= 5'd24) byte_val = be_byte32(price, 2'(body - 5'd21));
        end
        default: byte_val = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/itch_msg_serializer.sv
// itch_msg_serializer: accepts one structured ITCH order message per handshake and emits it
// as a big-endian byte stream with a valid/ready byte interface.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   msg_valid/msg_ready  message handshake; msg_ready is high only when idle
//   msg_type .. msg_timestamp   message fields
//   byte_out/valid_out/last_out registered byte stream; out_ready is the sink's accept
//   busy                 serializer not idle
//   err_unsupported      one-cycle pulse when an unknown type is accepted
//   msg_count            fully transmitted messages, wraps modulo 2^CNT_W
// Parameters: IDLE_GAP idle cycles after each message, CNT_W width of msg_count.
// Optional feature macro: ITCH_TIMESTAMP_EN (6-byte timestamp after the type byte).
module itch_msg_serializer
  import itch_pkg::*;
#(
  parameter int unsigned IDLE_GAP = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [3:0]       msg_type,
  input  logic [63:0]      msg_order_ref,
  input  logic             msg_side,
  input  logic [31:0]      msg_shares,
  input  logic [31:0]      msg_price,
  input  logic [63:0]      msg_new_order_ref,
  input  logic [47:0]      msg_timestamp,
  output logic [7:0]       byte_out,
  output logic             valid_out,
  input  logic             out_ready,
  output logic             last_out,
  output logic             busy,
  output logic             err_unsupported,
  output logic [CNT_W-1:0] msg_count
);

  state_e           state_q, state_d;
  logic [4:0]       idx_q, idx_d, len_q, len_d;
  logic [31:0]      gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d, last_q, last_d, err_q, err_d;

  // Registered field bundle
  logic [3:0]  type_q, type_d;
  logic [63:0] ref_q, ref_d, nref_q, nref_d;
  logic        side_q, side_d;
  logic [31:0] shares_q, shares_d, price_q, price_d;
  logic [47:0] ts_q;

  logic       known, load;
  logic [4:0] mux_idx;
  logic [7:0] mux_byte;

  assign known = (msg_len(msg_type) != 5'd0);
  assign load  = (state_q == StIdle) && msg_valid && known;

  // The mux looks at the next-state fields so the first byte can be registered on accept.
  assign type_d   = load ? msg_type          : type_q;
  assign ref_d    = load ? msg_order_ref     : ref_q;
  assign nref_d   = load ? msg_new_order_ref : nref_q;
  assign side_d   = load ? msg_side          : side_q;
  assign shares_d = load ? msg_shares        : shares_q;
  assign price_d  = load ? msg_price         : price_q;
  assign mux_idx  = (state_q == StIdle) ? 5'd0 : idx_q + 5'd1;

`ifdef ITCH_TIMESTAMP_EN
  logic [47:0] ts_d;
  assign ts_d = load ? msg_timestamp : ts_q;
  logic [47:0] mux_ts;
  assign mux_ts = ts_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_d;
  end
`else
  logic [47:0] mux_ts;
  logic        unused_ts;
  assign ts_q      = '0;
  assign mux_ts    = ts_q;
  assign unused_ts = ^msg_timestamp;
`endif

  itch_byte_mux u_byte_mux (
    .type_code (type_d),
    .order_ref (ref_d),
    .side      (side_d),
    .shares    (shares_d),
    .price     (price_d),
    .new_ref   (nref_d),
    .timestamp (mux_ts),
    .idx       (mux_idx),
    .byte_val  (mux_byte)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (msg_valid) begin
          if (known) begin
            state_d = StSend;
            idx_d   = 5'd0;
            len_d   = msg_len(msg_type);
            byte_d  = mux_byte;
            valid_d = 1'b1;
            last_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSend: begin
        // Outputs hold while the sink stalls; only a transfer moves idx.
        if (valid_q && out_ready) begin
          if (idx_q == len_q - 5'd1) begin
            cnt_d   = cnt_q + CNT_W'(1);
            idx_d   = 5'd0;
            byte_d  = 8'h00;
            valid_d = 1'b0;
            last_d  = 1'b0;
            gap_d   = '0;
            state_d = (IDLE_GAP > 0) ? StGap : StIdle;
          end else begin
            idx_d  = idx_q + 5'd1;
            byte_d = mux_byte;
            last_d = (idx_q + 5'd1 == len_q - 5'd1);
          end
        end
      end
      StGap: begin
        if (gap_q == IDLE_GAP - 1) state_d = StIdle;
        else                       gap_d   = gap_q + 32'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      len_q    <= '0;
      gap_q    <= '0;
      cnt_q    <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      type_q   <= '0;
      ref_q    <= '0;
      nref_q   <= '0;
      side_q   <= 1'b0;
      shares_q <= '0;
      price_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      err_q    <= err_d;
      type_q   <= type_d;
      ref_q    <= ref_d;
      nref_q   <= nref_d;
      side_q   <= side_d;
      shares_q <= shares_d;
      price_q  <= price_d;
    end
  end

  assign msg_ready       = (state_q == StIdle);
  assign busy            = (state_q != StIdle);
  assign byte_out        = byte_q;
  assign valid_out       = valid_q;
  assign last_out        = last_q;
  assign err_unsupported = err_q;
  assign msg_count       = cnt_q;

endmodule

// File: tb/tb_itch_msg_serializer.sv
// Self-checking bench for itch_msg_serializer: directed and random messages, compared
// against a byte-list reference model built from the message layouts.
module tb_itch_msg_serializer;

  localparam int unsigned GapCycles = 3;
  localparam int unsigned CntW      = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        msg_valid = 1'b0;
  logic        msg_ready;
  logic [3:0]  msg_type = '0;
  logic [63:0] msg_order_ref = '0;
  logic        msg_side = 1'b0;
  logic [31:0] msg_shares = '0;
  logic [31:0] msg_price = '0;
  logic [63:0] msg_new_order_ref = '0;
  logic [47:0] msg_timestamp = '0;
  logic [7:0]  byte_out;
  logic        valid_out;
  logic        out_ready = 1'b1;
  logic        last_out;
  logic        busy;
  logic        err_unsupported;
  logic [CntW-1:0] msg_count;

  always #5 clk = ~clk;

  itch_msg_serializer #(
    .IDLE_GAP (GapCycles),
    .CNT_W    (CntW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .msg_valid         (msg_valid),
    .msg_ready         (msg_ready),
    .msg_type          (msg_type),
    .msg_order_ref     (msg_order_ref),
    .msg_side          (msg_side),
    .msg_shares        (msg_shares),
    .msg_price         (msg_price),
    .msg_new_order_ref (msg_new_order_ref),
    .msg_timestamp     (msg_timestamp),
    .byte_out          (byte_out),
    .valid_out         (valid_out),
    .out_ready         (out_ready),
    .last_out          (last_out),
    .busy              (busy),
    .err_unsupported   (err_unsupported),
    .msg_count         (msg_count)
  );

  int total = 0;
  int bad = 0;
  int model_count = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic push_be(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(8'((v >> (8 * i)) & 64'hff));
  endtask

  // Reference layout: type byte, optional timestamp, then the type's fields MSB-first.
  task automatic build_model(input logic [3:0] t, input logic [63:0] oref, input logic side,
                             input logic [31:0] shares, input logic [31:0] price,
                             input logic [63:0] nref, input logic [47:0] ts);
    logic [7:0] ascii;
    exp_q.delete();
    case (t)
      4'd1: ascii = 8'h41;
      4'd2: ascii = 8'h44;
      4'd3: ascii = 8'h58;
      4'd4: ascii = 8'h45;
      4'd5: ascii = 8'h55;
      default: return;
    endcase
    exp_q.push_back(ascii);
`ifdef ITCH_TIMESTAMP_EN
    push_be({16'h0, ts}, 6);
`else
    if (ts == 48'h1) exp_q.push_back(8'h00);  // never taken; keeps ts referenced
    if (ts == 48'h1) void'(exp_q.pop_back());
`endif
    push_be(oref, 8);
    if (t == 4'd5) push_be(nref, 8);
    if (t == 4'd1) exp_q.push_back(side ? 8'h53 : 8'h42);
    if (t != 4'd2) push_be({32'h0, shares}, 4);
    if (t == 4'd1 || t == 4'd5) push_be({32'h0, price}, 4);
  endtask

  // Entered at a negedge with the DUT idle; returns at a negedge with msg_ready high.
  // mode: 0 sink always ready, 1 pattern 1,0,0,1, 2 random. abort_at >= 0 resets mid-message.
  task automatic send_msg(input logic [3:0] t, input logic [63:0] oref, input logic side,
                          input logic [31:0] shares, input logic [31:0] price,
                          input logic [63:0] nref, input logic [47:0] ts, input int mode,
                          input int abort_at);
    int len, idx, c, gap;
    msg_type = t; msg_order_ref = oref; msg_side = side; msg_shares = shares;
    msg_price = price; msg_new_order_ref = nref; msg_timestamp = ts;
    msg_valid = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    build_model(t, oref, side, shares, price, nref, ts);
    len = exp_q.size();
    if (len == 0) begin
      check_eq("err_pulse", 64'(err_unsupported), 64'd1);
      check_eq("unsup_valid", 64'(valid_out), 64'd0);
      check_eq("unsup_ready", 64'(msg_ready), 64'd1);
      @(negedge clk);
      check_eq("err_clear", 64'(err_unsupported), 64'd0);
      check_eq("unsup_valid2", 64'(valid_out), 64'd0);
      check_eq("unsup_count", 64'(msg_count), 64'(model_count % (1 << CntW)));
      return;
    end
    check_eq("ready_low", 64'(msg_ready), 64'd0);
    check_eq("busy_high", 64'(busy), 64'd1);
    check_eq("no_err", 64'(err_unsupported), 64'd0);
    idx = 0;
    c = 0;
    while (idx < len && c < 400) begin
      if (abort_at == idx) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 64'(valid_out), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_ready", 64'(msg_ready), 64'd1);
        check_eq("rst_count", 64'(msg_count), 64'd0);
        model_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        return;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 4 == 0) || (c % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      check_eq("valid_out", 64'(valid_out), 64'd1);
      check_eq($sformatf("byte[%0d]", idx), 64'(byte_out), 64'(exp_q[idx]));
      check_eq($sformatf("last[%0d]", idx), 64'(last_out), 64'(idx == len - 1));
      if (out_ready) idx++;
      c++;
      @(negedge clk);
    end
    check_eq("send_done", 64'(idx), 64'(len));
    model_count++;
    check_eq("msg_count", 64'(msg_count), 64'(model_count % (1 << CntW)));
    check_eq("post_valid", 64'(valid_out), 64'd0);
    gap = 0;
    while (!msg_ready && gap < 50) begin
      check_eq("gap_valid", 64'(valid_out), 64'd0);
      gap++;
      @(negedge clk);
    end
    check_eq("gap_len", 64'(gap), 64'(GapCycles));
    check_eq("idle_valid", 64'(valid_out), 64'd0);
    check_eq("idle_busy", 64'(busy), 64'd0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [3:0] t;
    logic [3:0] bad_types [4];
    bad_types[0] = 4'd0; bad_types[1] = 4'd6; bad_types[2] = 4'd7; bad_types[3] = 4'd15;

    #1;
    check_eq("reset_valid", 64'(valid_out), 64'd0);
    check_eq("reset_byte", 64'(byte_out), 64'd0);
    check_eq("reset_last", 64'(last_out), 64'd0);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_err", 64'(err_unsupported), 64'd0);
    check_eq("reset_count", 64'(msg_count), 64'd0);
    check_eq("reset_ready", 64'(msg_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send_msg(4'd2, 64'h0102030405060708, 1'b0, 32'd0, 32'd0, 64'd0, 48'h0000a1b2c3d4, 0, -1);
    send_msg(4'd1, 64'h11, 1'b1, 32'd100, 32'h0001E240, 64'd0, 48'h123456789abc, 0, -1);
    send_msg(4'd5, rnd64(), 1'b0, $urandom(), $urandom(), rnd64(), 48'(rnd64()), 1, -1);
    send_msg(4'd7, rnd64(), 1'b0, $urandom(), $urandom(), rnd64(), 48'(rnd64()), 0, -1);
    send_msg(4'd2, rnd64(), 1'b0, $urandom(), $urandom(), rnd64(), 48'(rnd64()), 0, -1);
    send_msg(4'd0, rnd64(), 1'b1, $urandom(), $urandom(), rnd64(), 48'(rnd64()), 0, -1);
    send_msg(4'd1, rnd64(), 1'b0, $urandom(), $urandom(), rnd64(), 48'(rnd64()), 0, 5);
    send_msg(4'd3, rnd64(), 1'b1, $urandom(), $urandom(), rnd64(), 48'(rnd64()), 0, -1);
    send_msg(4'd2, rnd64(), 1'b0, $urandom(), $urandom(), rnd64(), 48'(rnd64()), 0, -1);
    send_msg(4'd2, rnd64(), 1'b0, $urandom(), $urandom(), rnd64(), 48'(rnd64()), 0, -1);
    send_msg(4'd4, rnd64(), 1'b1, $urandom(), $urandom(), rnd64(), 48'(rnd64()), 2, -1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 8) t = 4'($urandom_range(1, 5));
      else                          t = bad_types[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send_msg(t, rnd64(), 1'($urandom_range(0, 1)), $urandom(), $urandom(), rnd64(),
               48'(rnd64()), int'($urandom_range(0, 2)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
